// File: rtl/clock_pkg.sv
// Shared definitions for the clock mode sequencer: FSM state codes,
// digit selectors, digit limits and the wrapping digit-increment helper.
package clock_pkg;

  // Mode FSM state codes; 14 and 15 are unused and recover to ST_NORMAL.
  typedef enum logic [3:0] {
    ST_NORMAL    = 4'd0,
    ST_ALM_HT    = 4'd1,
    ST_ALM_HU    = 4'd2,
    ST_ALM_MT    = 4'd3,
    ST_ALM_MU    = 4'd4,
    ST_ALM_ON    = 4'd5,
    ST_SW        = 4'd6,
    ST_SW_SPLIT  = 4'd7,
    ST_SW_CLR    = 4'd8,
    ST_SET_HT    = 4'd9,
    ST_SET_HU    = 4'd10,
    ST_SET_MT    = 4'd11,
    ST_SET_MU    = 4'd12,
    ST_SET_APPLY = 4'd13
  } mode_state_t;

  // Which digit of an hh:mm editor the increment strobe acts on.
  typedef enum logic [1:0] {
    DIG_HT = 2'd0,
    DIG_HU = 2'd1,
    DIG_MT = 2'd2,
    DIG_MU = 2'd3
  } digit_sel_t;

  localparam logic [3:0] HT_MAX       = 4'd2;
  localparam logic [3:0] HU_MAX       = 4'd9;
  localparam logic [3:0] HU_MAX_AT_20 = 4'd3;
  localparam logic [3:0] MT_MAX       = 4'd5;
  localparam logic [3:0] MU_MAX       = 4'd9;

  // Increment a BCD digit, wrapping to 0 past max (also recovers from >max).
  function automatic logic [3:0] wrap_inc(input logic [3:0] val, input logic [3:0] max);
    return (val >= max) ? 4'd0 : val + 4'd1;
  endfunction

endpackage

// File: rtl/hhmm_editor.sv
// Four-digit hh:mm editor: digit registers with per-digit wrap, the
// hours-units clamp when hours tens reaches 2, and binary conversion.
module hhmm_editor
  import clock_pkg::*;
#(
  parameter int HOUR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  digit_sel_t        sel,
  output logic [HOUR_W-1:0] hours,
  output logic [HOUR_W-1:0] minutes
);

  logic [3:0] ht_reg, hu_reg, mt_reg, mu_reg;
  logic [3:0] ht_next, hu_next, mt_next, mu_next;

  // Next digit values: only the selected digit moves on an increment strobe.
  always_comb begin
    ht_next = ht_reg;
    hu_next = hu_reg;
    mt_next = mt_reg;
    mu_next = mu_reg;
    if (inc) begin
      case (sel)
        DIG_HT: begin
          ht_next = wrap_inc(ht_reg, HT_MAX);
          // Entering the 20s must not leave an illegal 24..29 behind.
          if (ht_next == HT_MAX && hu_reg > HU_MAX_AT_20) hu_next = HU_MAX_AT_20;
        end
        DIG_HU: hu_next = wrap_inc(hu_reg, (ht_reg == HT_MAX) ? HU_MAX_AT_20 : HU_MAX);
        DIG_MT: mt_next = wrap_inc(mt_reg, MT_MAX);
        DIG_MU: mu_next = wrap_inc(mu_reg, MU_MAX);
        default: ;
      endcase
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ht_reg <= 4'd0;
      hu_reg <= 4'd0;
      mt_reg <= 4'd0;
      mu_reg <= 4'd0;
    end else begin
      ht_reg <= ht_next;
      hu_reg <= hu_next;
      mt_reg <= mt_next;
      mu_reg <= mu_next;
    end
  end

  assign hours   = HOUR_W'(ht_reg) * HOUR_W'(10) + HOUR_W'(hu_reg);
  assign minutes = HOUR_W'(mt_reg) * HOUR_W'(10) + HOUR_W'(mu_reg);

endmodule

// File: rtl/clock_mode_sequencer.sv
// Mode controller for the digital clock: button edge detection, the mode
// FSM, alarm/set-time editors and stopwatch/time-load strobes.
// Optional feature macro: CLOCK_SW_SPLIT_EN enables the SW_SPLIT state.
module clock_mode_sequencer
  import clock_pkg::*;
#(
  parameter int HOUR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_button,
  input  logic              inc_button,
  output logic [HOUR_W-1:0] alarm_hours,
  output logic [HOUR_W-1:0] alarm_minutes,
  output logic              alarm_on,
  output logic [HOUR_W-1:0] set_hours,
  output logic [HOUR_W-1:0] set_minutes,
  output logic              time_load,
  output logic              sw_run,
  output logic              sw_clear,
  output logic              sw_freeze,
  output logic [3:0]        mode_state
);

  mode_state_t state_reg, state_next;
  logic        mode_prev_reg, inc_prev_reg;
  logic        alarm_on_reg, alarm_on_next;
  logic        sw_run_reg, sw_run_next;
  logic        time_load_reg, time_load_next;
  logic        sw_clear_reg, sw_clear_next;
  logic        mode_evt, inc_evt;
  logic        alm_inc, set_inc;
  digit_sel_t  alm_sel, set_sel;

  // Rising-edge events; a simultaneous mode event swallows the increment.
  assign mode_evt = mode_button & ~mode_prev_reg;
  assign inc_evt  = inc_button & ~inc_prev_reg & ~mode_evt;

  // Route increment events to the editor and digit owned by the current state.
  always_comb begin
    alm_inc = 1'b0;
    alm_sel = DIG_HT;
    set_inc = 1'b0;
    set_sel = DIG_HT;
    case (state_reg)
      ST_ALM_HT: begin alm_inc = inc_evt; alm_sel = DIG_HT; end
      ST_ALM_HU: begin alm_inc = inc_evt; alm_sel = DIG_HU; end
      ST_ALM_MT: begin alm_inc = inc_evt; alm_sel = DIG_MT; end
      ST_ALM_MU: begin alm_inc = inc_evt; alm_sel = DIG_MU; end
      ST_SET_HT: begin set_inc = inc_evt; set_sel = DIG_HT; end
      ST_SET_HU: begin set_inc = inc_evt; set_sel = DIG_HU; end
      ST_SET_MT: begin set_inc = inc_evt; set_sel = DIG_MT; end
      ST_SET_MU: begin set_inc = inc_evt; set_sel = DIG_MU; end
      default: ;
    endcase
  end

  // Mode FSM next state plus the alarm-enable, stopwatch and load controls.
  always_comb begin
    state_next     = state_reg;
    alarm_on_next  = alarm_on_reg;
    sw_run_next    = sw_run_reg;
    time_load_next = 1'b0;
    sw_clear_next  = 1'b0;
    case (state_reg)
      ST_NORMAL: if (mode_evt) state_next = ST_ALM_HT;
      ST_ALM_HT: if (mode_evt) state_next = ST_ALM_HU;
      ST_ALM_HU: if (mode_evt) state_next = ST_ALM_MT;
      ST_ALM_MT: if (mode_evt) state_next = ST_ALM_MU;
      ST_ALM_MU: if (mode_evt) state_next = ST_ALM_ON;
      ST_ALM_ON: begin
        if (mode_evt) state_next = ST_SW;
        else if (inc_evt) alarm_on_next = ~alarm_on_reg;
      end
      ST_SW: begin
        if (mode_evt) begin
`ifdef CLOCK_SW_SPLIT_EN
          if (sw_run_reg) begin
            state_next = ST_SW_SPLIT;
          end else begin
            state_next    = ST_SW_CLR;
            sw_run_next   = 1'b0;
            sw_clear_next = 1'b1;
          end
`else
          state_next    = ST_SW_CLR;
          sw_run_next   = 1'b0;
          sw_clear_next = 1'b1;
`endif
        end else if (inc_evt) begin
          sw_run_next = ~sw_run_reg;
        end
      end
`ifdef CLOCK_SW_SPLIT_EN
      ST_SW_SPLIT: begin
        if (mode_evt) state_next = ST_SW;
        else if (inc_evt) sw_run_next = ~sw_run_reg;
      end
`endif
      ST_SW_CLR: if (mode_evt) state_next = ST_SET_HT;
      ST_SET_HT: if (mode_evt) state_next = ST_SET_HU;
      ST_SET_HU: if (mode_evt) state_next = ST_SET_MT;
      ST_SET_MT: if (mode_evt) state_next = ST_SET_MU;
      ST_SET_MU: if (mode_evt) state_next = ST_SET_APPLY;
      ST_SET_APPLY: begin
        if (mode_evt) state_next = ST_NORMAL;
        else if (inc_evt) time_load_next = 1'b1;
      end
      default: state_next = ST_NORMAL;
    endcase
  end

  // State, button history and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_NORMAL;
      mode_prev_reg <= 1'b0;
      inc_prev_reg  <= 1'b0;
      alarm_on_reg  <= 1'b0;
      sw_run_reg    <= 1'b0;
      time_load_reg <= 1'b0;
      sw_clear_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_prev_reg <= mode_button;
      inc_prev_reg  <= inc_button;
      alarm_on_reg  <= alarm_on_next;
      sw_run_reg    <= sw_run_next;
      time_load_reg <= time_load_next;
      sw_clear_reg  <= sw_clear_next;
    end
  end

  hhmm_editor #(.HOUR_W(HOUR_W)) u_alarm_editor (
    .clk     (clk),
    .rst     (rst),
    .inc     (alm_inc),
    .sel     (alm_sel),
    .hours   (alarm_hours),
    .minutes (alarm_minutes)
  );

  hhmm_editor #(.HOUR_W(HOUR_W)) u_set_editor (
    .clk     (clk),
    .rst     (rst),
    .inc     (set_inc),
    .sel     (set_sel),
    .hours   (set_hours),
    .minutes (set_minutes)
  );

  assign alarm_on   = alarm_on_reg;
  assign sw_run     = sw_run_reg;
  assign time_load  = time_load_reg;
  assign sw_clear   = sw_clear_reg;
  assign mode_state = state_reg;

`ifdef CLOCK_SW_SPLIT_EN
  assign sw_freeze = (state_reg == ST_SW_SPLIT);
`else
  assign sw_freeze = 1'b0;
`endif

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Directed self-checking bench for clock_mode_sequencer.
module tb_clock_mode_sequencer;

  localparam int HOUR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mode_button = 1'b0;
  logic              inc_button = 1'b0;
  logic [HOUR_W-1:0] alarm_hours, alarm_minutes, set_hours, set_minutes;
  logic              alarm_on, time_load, sw_run, sw_clear, sw_freeze;
  logic [3:0]        mode_state;

  int checks = 0;
  int errors = 0;
  int load1, load2, clear1, clear2;

  clock_mode_sequencer #(.HOUR_W(HOUR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .mode_button   (mode_button),
    .inc_button    (inc_button),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .alarm_on      (alarm_on),
    .set_hours     (set_hours),
    .set_minutes   (set_minutes),
    .time_load     (time_load),
    .sw_run        (sw_run),
    .sw_clear      (sw_clear),
    .sw_freeze     (sw_freeze),
    .mode_state    (mode_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One button press: high for one sample, then low for one sample.
  task automatic press(input logic m, input logic i);
    mode_button = m;
    inc_button  = i;
    tick();
    load1  = int'(time_load);
    clear1 = int'(sw_clear);
    mode_button = 1'b0;
    inc_button  = 1'b0;
    tick();
    load2  = int'(time_load);
    clear2 = int'(sw_clear);
  endtask

  task automatic modes(input int n);
    for (int k = 0; k < n; k++) press(1'b1, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_state", int'(mode_state), 0);
    check("rst_alm_h", int'(alarm_hours), 0);
    check("rst_alm_m", int'(alarm_minutes), 0);
    check("rst_alm_on", int'(alarm_on), 0);
    check("rst_set_h", int'(set_hours), 0);
    check("rst_sw_run", int'(sw_run), 0);
    check("rst_freeze", int'(sw_freeze), 0);
    check("rst_load", int'(time_load), 0);
    check("rst_clear", int'(sw_clear), 0);

    // Increments in NORMAL are ignored
    incs(1);
    check("normal_inc_state", int'(mode_state), 0);

    // Alarm entry -> 23:45, alarm on
    modes(1); incs(2);
    check("alm_ht_20", int'(alarm_hours), 20);
    modes(1); incs(7);
    modes(1); incs(4);
    modes(1); incs(5);
    modes(1); incs(1);
    check("alm_hours", int'(alarm_hours), 23);
    check("alm_minutes", int'(alarm_minutes), 45);
    check("alm_on", int'(alarm_on), 1);
    check("alm_state", int'(mode_state), 5);

    // Stopwatch run / stop / clear
    modes(1);
    check("sw_state", int'(mode_state), 6);
    incs(1);
    check("sw_run_on", int'(sw_run), 1);
    repeat (40) tick();
    check("sw_run_held", int'(sw_run), 1);
    incs(1);
    check("sw_run_off", int'(sw_run), 0);
    modes(1);
    check("sw_clear_pulse", clear1, 1);
    check("sw_clear_drop", clear2, 0);
    check("sw_clr_state", int'(mode_state), 8);

    // Set time -> 23:44 and load
    modes(1); incs(2);
    modes(1); incs(3);
    modes(1); incs(4);
    modes(1); incs(4);
    modes(1);
    check("apply_state", int'(mode_state), 13);
    check("apply_no_load", int'(time_load), 0);
    incs(1);
    check("load_pulse", load1, 1);
    check("load_drop", load2, 0);
    check("set_hours", int'(set_hours), 23);
    check("set_minutes", int'(set_minutes), 44);
    check("alm_indep_h", int'(alarm_hours), 23);
    check("alm_indep_m", int'(alarm_minutes), 45);
    modes(1);
    check("back_normal", int'(mode_state), 0);

    // Split (or plain clear without the split feature)
    modes(6);
    check("sw_again", int'(mode_state), 6);
    incs(1);
    check("sw_run_on2", int'(sw_run), 1);
    modes(1);
`ifdef CLOCK_SW_SPLIT_EN
    check("split_state", int'(mode_state), 7);
    check("split_freeze", int'(sw_freeze), 1);
    check("split_run", int'(sw_run), 1);
    check("split_no_clear", clear1, 0);
    modes(1);
    check("unsplit_state", int'(mode_state), 6);
    check("unsplit_freeze", int'(sw_freeze), 0);
    incs(1);
    check("split_stop", int'(sw_run), 0);
    modes(1);
`endif
    check("split_clear", clear1, 1);
    check("split_clr_state", int'(mode_state), 8);
    check("split_clr_run", int'(sw_run), 0);
    check("split_clr_freeze", int'(sw_freeze), 0);

    // SW_CLR ignores increments
    incs(1);
    check("clr_inc_ignored", clear1, 0);

    // Clamp: HT=0, HU=9, then HT to 2 clamps HU to 3
    modes(1);
    check("set_ht_state", int'(mode_state), 9);
    incs(1);
    check("ht_wrap", int'(set_hours), 3);
    modes(1); incs(6);
    check("hu_nine", int'(set_hours), 9);
    modes(12);
    check("set_ht_again", int'(mode_state), 9);
    incs(1);
    check("hours_19", int'(set_hours), 19);
    incs(1);
    check("clamp_23", int'(set_hours), 23);
    press(1'b1, 1'b1);
    check("both_state", int'(mode_state), 10);
    check("both_digit", int'(set_hours), 23);

    // Reset during operation
    modes(10);
    check("sw_third", int'(mode_state), 6);
    incs(1);
`ifdef CLOCK_SW_SPLIT_EN
    modes(1);
    check("pre_rst_state", int'(mode_state), 7);
`endif
    check("pre_rst_alm_on", int'(alarm_on), 1);
    rst = 1'b1;
    mode_button = 1'b1;
    inc_button = 1'b1;
    tick();
    rst = 1'b0;
    mode_button = 1'b0;
    inc_button = 1'b0;
    check("mid_rst_state", int'(mode_state), 0);
    check("mid_rst_alm_on", int'(alarm_on), 0);
    check("mid_rst_run", int'(sw_run), 0);
    check("mid_rst_freeze", int'(sw_freeze), 0);
    check("mid_rst_alm_h", int'(alarm_hours), 0);
    check("mid_rst_set_h", int'(set_hours), 0);
    check("mid_rst_set_m", int'(set_minutes), 0);
    tick();

    // Held increment button gives exactly one event
    modes(1);
    check("hold_state", int'(mode_state), 1);
    inc_button = 1'b1;
    repeat (10) tick();
    inc_button = 1'b0;
    tick();
    check("hold_one_inc", int'(alarm_hours), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
